// File: rtl/latch_arb_pkg.sv
// Shared types for the latch bank write sequencer: FSM states, requester id, requester count.
package latch_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, DONE} state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the non-winner when adv_i is strobed.
module rr_arbiter2
  import latch_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  input  req_id_t            win_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  req_id_t ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr_q <= 1'b0;
    else if (adv_i) ptr_q <= ~win_i;
  end

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Sequences SETUP/OPEN/HOLD/DONE write windows into a D-latch bank for two round-robin requesters.
// Optional readback compare of the written latch is enabled by LATCH_READBACK_CHECK_EN.
module latch_bank_arbiter
  import latch_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int PULSE_W = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [ADDR_W-1:0]              addr0,
  input  logic [DATA_W-1:0]              data0,
  input  logic [ADDR_W-1:0]              addr1,
  input  logic [DATA_W-1:0]              data1,
`ifdef LATCH_READBACK_CHECK_EN
  input  logic [DATA_W*(2**ADDR_W)-1:0]  lat_q,
  output logic                           wr_err,
`endif
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic [DATA_W-1:0]              lat_d,
  output logic [2**ADDR_W-1:0]           lat_en
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_W - 1);

  if (PULSE_W < 1) begin : g_bad_pulse_w
    $error("latch_bank_arbiter: PULSE_W must be >= 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_id_t            win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DEPTH-1:0]   lat_en_q, lat_en_d;
  logic [NUM_REQ-1:0] gnt;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .adv_i (state_q == DONE),
    .win_i (win_q),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      lat_en_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lat_en_q <= lat_en_d;
    end
  end

  // Capture happens on the grant edge only; inputs are ignored for the rest of the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SETUP;
        win_d   = gnt[1];
        addr_d  = gnt[1] ? addr1 : addr0;
        data_d  = gnt[1] ? data1 : data0;
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables are registered from the next state so they toggle cleanly with the OPEN window.
  always_comb begin
    lat_en_d = '0;
    if (state_d == OPEN) lat_en_d[addr_q] = 1'b1;
    busy  = (state_q != IDLE);
    lat_d = (state_q != IDLE) ? data_q : '0;
    ack   = '0;
    if (state_q == DONE) ack[win_q] = 1'b1;
  end

  assign lat_en = lat_en_q;

`ifdef LATCH_READBACK_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (state_q == HOLD)  err_q <= (lat_q[addr_q*DATA_W +: DATA_W] != data_q);
  end

  assign wr_err = (state_q == DONE) && err_q;
`endif

endmodule
